// File: rtl/uop_fill.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uop_fill                                                      |
// | Purpose  : Write-side engine of the uop buffer. Packs up to two decoded  |
// |            instructions per cycle into bundle pairs, writes them into a  |
// |            ring at a wrapping address, tracks occupancy against the      |
// |            fetch consume strobe and back-pressures decode when full.     |
// | Option   : UOP_FILL_PACK_EN - enables the hold register, pairing of      |
// |            lone instructions across beats, flush and idle timeout.       |
// |            Undefined: every accepted beat writes {in_1, in_2 or NOP}.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module uop_fill #(
    parameter int UOP_BUF_SIZE  = 16,
    parameter int FLUSH_TIMEOUT = 4,
    parameter int INSTR_W       = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            clear,
    input  logic                            prev_valid,
    input  logic                            in1_valid,
    input  logic                            in2_valid,
    input  logic [INSTR_W-1:0]              in_1,
    input  logic [INSTR_W-1:0]              in_2,
    input  logic                            flush,
    output logic                            stalled,
    input  logic                            rd_consume,
    output logic                            wr_en,
    output logic [$clog2(UOP_BUF_SIZE)-1:0] wr_addr,
    output logic [2*INSTR_W-1:0]            wr_data,
    output logic [$clog2(UOP_BUF_SIZE):0]   count,
    output logic                            full,
    output logic                            empty
);

    localparam int                  c_aw    = $clog2(UOP_BUF_SIZE);
    localparam int                  c_cw    = c_aw + 1;
    localparam logic [c_cw-1:0]     c_depth = c_cw'(UOP_BUF_SIZE);
    localparam logic [INSTR_W-1:0]  c_nop   = '0;

    logic                   w_beat;
    logic                   w_space;
    logic                   w_dec;
    logic                   w_accept;
    logic                   w_wr;
    logic [2*INSTR_W-1:0]   w_wr_data;

    logic                   r_wr_en;
    logic [c_aw-1:0]        r_wr_addr;
    logic [2*INSTR_W-1:0]   r_wr_data;
    logic [c_cw-1:0]        r_count;

    assign w_beat  = prev_valid;
    // A consume on this edge frees a slot, so a write may go in even at full.
    assign w_space = (r_count < c_depth) || rd_consume;
    // A consume while the ring is empty has nothing to retire.
    assign w_dec   = rd_consume && (r_count != '0);

`ifdef UOP_FILL_PACK_EN
    localparam int              c_iw      = $clog2(FLUSH_TIMEOUT + 1);
    localparam logic [c_iw-1:0] c_timeout = c_iw'(FLUSH_TIMEOUT);

    logic                   r_hold_v;
    logic [INSTR_W-1:0]     r_hold_q;
    logic [c_iw-1:0]        r_idle;
    logic                   w_hold_v;
    logic [INSTR_W-1:0]     w_hold_q;
    logic [1:0]             w_n;
    logic [1:0]             w_total;
    logic                   w_expire;

    assign w_n      = w_beat ? ({1'b0, in1_valid} + {1'b0, in2_valid}) : 2'd0;
    assign w_total  = w_n + {1'b0, r_hold_v};
    assign w_expire = flush || (r_idle == c_timeout);

    // Decide accept/write/hold for this cycle; oldest instruction is always the held one.
    always_comb begin
        w_accept  = 1'b0;
        w_wr      = 1'b0;
        w_wr_data = '0;
        w_hold_v  = r_hold_v;
        w_hold_q  = r_hold_q;
        if (!clear) begin
            if (w_total >= 2'd2) begin
                if (w_space) begin
                    w_accept  = 1'b1;
                    w_wr      = 1'b1;
                    w_wr_data = r_hold_v ? {r_hold_q, in_1} : {in_1, in_2};
                    // Three candidates: the youngest (in_2) waits for a partner.
                    w_hold_v  = (w_total == 2'd3);
                    if (w_total == 2'd3) begin
                        w_hold_q = in_2;
                    end
                end
            end else if (w_n == 2'd1) begin
                // Hold register is empty here; park the lone instruction or push it out.
                if (!flush) begin
                    w_accept = 1'b1;
                    w_hold_v = 1'b1;
                    w_hold_q = in_1;
                end else if (w_space) begin
                    w_accept  = 1'b1;
                    w_wr      = 1'b1;
                    w_wr_data = {in_1, c_nop};
                end
            end else begin
                // No instructions arriving: an empty beat is trivially taken.
                w_accept = w_beat;
                if (r_hold_v && w_expire && w_space) begin
                    w_wr      = 1'b1;
                    w_wr_data = {r_hold_q, c_nop};
                    w_hold_v  = 1'b0;
                end
            end
        end
    end

    // Hold register and idle counter; the counter only runs while something is held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hold_v <= 1'b0;
            r_hold_q <= '0;
            r_idle   <= '0;
        end else if (clear) begin
            r_hold_v <= 1'b0;
            r_idle   <= '0;
        end else begin
            r_hold_v <= w_hold_v;
            r_hold_q <= w_hold_q;
            if (!r_hold_v || w_beat) begin
                r_idle <= '0;
            end else if (r_idle != c_timeout) begin
                r_idle <= r_idle + c_iw'(1);
            end
        end
    end
`else
    // flush and the timeout have no meaning without a hold register.
    logic w_unused;
    assign w_unused = flush ^ (FLUSH_TIMEOUT > 0);

    // One bundle per accepted beat, empty second slot padded with NOP.
    always_comb begin
        w_accept  = w_beat && w_space && !clear;
        w_wr      = w_accept && in1_valid;
        w_wr_data = {in_1, (in2_valid ? in_2 : c_nop)};
    end
`endif

    // Decode holds whenever its beat is not taken, including during clear.
    assign stalled = w_beat && !w_accept;

    // Registered write port and occupancy; the slot is reserved at decision time.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_count   <= '0;
        end else if (clear) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_count   <= '0;
        end else begin
            r_wr_en   <= w_wr;
            // Advance past the address just written; power-of-two depth wraps naturally.
            r_wr_addr <= r_wr_addr + c_aw'(r_wr_en);
            if (w_wr) begin
                r_wr_data <= w_wr_data;
            end
            r_count   <= r_count + c_cw'(w_wr) - c_cw'(w_dec);
        end
    end

    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign count   = r_count;
    assign full    = (r_count == c_depth);
    assign empty   = (r_count == '0);

endmodule
`default_nettype wire

// File: tb/tb_uop_fill.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_uop_fill                                                   |
// | Purpose  : Self-checking bench for uop_fill: directed scenarios plus a   |
// |            randomized run against a queue-based reference model.        |
// |            Follows UOP_FILL_PACK_EN the same way the design does.        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_uop_fill;

    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 4;
    localparam int W       = 32;
    localparam int AW      = $clog2(DEPTH);
    localparam int CW      = AW + 1;

    logic            clk = 1'b0;
    logic            reset;
    logic            clear;
    logic            prev_valid;
    logic            in1_valid;
    logic            in2_valid;
    logic [W-1:0]    in_1;
    logic [W-1:0]    in_2;
    logic            flush;
    logic            stalled;
    logic            rd_consume;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [2*W-1:0]  wr_data;
    logic [CW-1:0]   count;
    logic            full;
    logic            empty;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    logic [W-1:0]    m_hold[$];
    int              m_idle;
    int              m_count;
    int              m_next;
    bit              e_wr_en;
    int              e_wr_addr;
    logic [2*W-1:0]  e_wr_data;
    bit              e_stall;
    logic            s_stalled;

    uop_fill #(
        .UOP_BUF_SIZE (DEPTH),
        .FLUSH_TIMEOUT(TIMEOUT),
        .INSTR_W      (W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .prev_valid(prev_valid),
        .in1_valid (in1_valid),
        .in2_valid (in2_valid),
        .in_1      (in_1),
        .in_2      (in_2),
        .flush     (flush),
        .stalled   (stalled),
        .rd_consume(rd_consume),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic model_reset();
        m_hold.delete();
        m_idle    = 0;
        m_count   = 0;
        m_next    = 0;
        e_wr_en   = 1'b0;
        e_wr_addr = 0;
        e_wr_data = '0;
        e_stall   = 1'b0;
    endtask

    task automatic apply_reset();
        prev_valid = 1'b0; in1_valid = 1'b0; in2_valid = 1'b0;
        flush = 1'b0; rd_consume = 1'b0; clear = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    // Drive one cycle of inputs, sample stalled before the edge, step the model,
    // and return 1 time unit after the edge with registered outputs settled.
    task automatic drive(input bit pv, input bit v1, input bit v2,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit fl, input bit rc, input bit cl);
        bit             space;
        bit             acc;
        bit             wr;
        logic [2*W-1:0] data;
`ifdef UOP_FILL_PACK_EN
        logic [W-1:0]   pend[$];
        int             nb;
        bit             had_hold;
`endif
        prev_valid = pv; in1_valid = v1; in2_valid = v2;
        in_1 = a; in_2 = b; flush = fl; rd_consume = rc; clear = cl;
        #2;
        s_stalled = stalled;
        space = (m_count < DEPTH) || rc;
        acc   = 1'b0;
        wr    = 1'b0;
        data  = '0;
        if (cl) begin
            m_hold.delete();
            m_idle    = 0;
            m_count   = 0;
            m_next    = 0;
            e_wr_en   = 1'b0;
            e_wr_addr = 0;
            e_stall   = pv;
        end else begin
`ifdef UOP_FILL_PACK_EN
            // Candidates in age order: held instruction first, then the beat.
            pend     = m_hold;
            had_hold = (m_hold.size() != 0);
            nb       = 0;
            if (pv && v1) begin pend.push_back(a); nb++; end
            if (pv && v2) begin pend.push_back(b); nb++; end
            if (pend.size() >= 2) begin
                if (space) begin
                    acc  = 1'b1;
                    wr   = 1'b1;
                    data = {pend[0], pend[1]};
                    m_hold.delete();
                    if (pend.size() == 3) m_hold.push_back(pend[2]);
                end
            end else if (nb == 1) begin
                if (!fl) begin
                    acc = 1'b1;
                    m_hold.push_back(pend[0]);
                end else if (space) begin
                    acc  = 1'b1;
                    wr   = 1'b1;
                    data = {pend[0], W'(0)};
                end
            end else begin
                acc = pv;
                if (had_hold && (fl || m_idle >= TIMEOUT) && space) begin
                    wr   = 1'b1;
                    data = {m_hold[0], W'(0)};
                    m_hold.delete();
                end
            end
            if (!had_hold || pv) m_idle = 0;
            else if (m_idle < TIMEOUT) m_idle++;
`else
            acc  = pv && space;
            wr   = acc && v1;
            data = {a, (v2 ? b : W'(0))};
`endif
            e_stall = pv && !acc;
            e_wr_en = wr;
            if (wr) begin
                e_wr_addr = m_next;
                e_wr_data = data;
                m_next    = (m_next + 1) % DEPTH;
            end
            m_count = m_count + (wr ? 1 : 0) - ((rc && m_count > 0) ? 1 : 0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [W-1:0] a;
        logic [W-1:0] b;
        n_cmp++; if (count !== '0 || empty !== 1'b1) begin n_fail++;
            $display("FAIL reset_initial: count=%0d empty=%b want 0/1", count, empty); end
        drive(1, 1, 1, 32'h1111_0001, 32'h2222_0002, 0, 0, 0);
        drive(1, 1, 0, 32'h3333_0003, 32'h0, 0, 0, 0);
        prev_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        n_cmp++; if ({wr_en, wr_addr, count, full, empty, stalled} !== {1'b0, AW'(0), CW'(0), 1'b0, 1'b1, 1'b0}) begin n_fail++;
            $display("FAIL reset_mid: wr_en=%b addr=%0d count=%0d full=%b empty=%b stalled=%b", wr_en, wr_addr, count, full, empty, stalled); end
        n_cmp++; if (wr_data !== '0) begin n_fail++;
            $display("FAIL reset_data: wr_data=%h want 0", wr_data); end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        a = 32'hA5A5_0001; b = 32'hA5A5_0002;
        drive(1, 1, 1, a, b, 0, 0, 0);
        n_cmp++; if ({wr_en, wr_addr} !== {1'b1, AW'(0)} || wr_data !== {a, b}) begin n_fail++;
            $display("FAIL reset_first_write: wr_en=%b addr=%0d data=%h want 1/0/%h", wr_en, wr_addr, wr_data, {a, b}); end
    endtask

`ifdef UOP_FILL_PACK_EN
    task automatic test_packing();
        logic [W-1:0] ia, ib, ic, id, ie;
        ia = 32'h0A0A_0001; ib = 32'h0B0B_0002; ic = 32'h0C0C_0003;
        id = 32'h0D0D_0004; ie = 32'h0E0E_0005;
        apply_reset();
        drive(1, 1, 0, ia, 32'h0, 0, 0, 0);
        n_cmp++; if (wr_en !== 1'b0 || s_stalled !== 1'b0) begin n_fail++;
            $display("FAIL pack_a: wr_en=%b stalled=%b want 0/0", wr_en, s_stalled); end
        drive(1, 1, 0, ib, 32'h0, 0, 0, 0);
        n_cmp++; if ({wr_en, wr_addr, count} !== {1'b1, AW'(0), CW'(1)} || wr_data !== {ia, ib}) begin n_fail++;
            $display("FAIL pack_ab: wr_en=%b addr=%0d count=%0d data=%h want 1/0/1/%h", wr_en, wr_addr, count, wr_data, {ia, ib}); end
        drive(1, 1, 1, ic, id, 0, 0, 0);
        n_cmp++; if ({wr_en, wr_addr, count} !== {1'b1, AW'(1), CW'(2)} || wr_data !== {ic, id}) begin n_fail++;
            $display("FAIL pack_cd: wr_en=%b addr=%0d count=%0d data=%h want 1/1/2/%h", wr_en, wr_addr, count, wr_data, {ic, id}); end
        drive(1, 1, 0, ie, 32'h0, 0, 0, 0);
        n_cmp++; if (wr_en !== 1'b0) begin n_fail++;
            $display("FAIL pack_e_held: wr_en=%b want 0", wr_en); end
        for (int k = 0; k < TIMEOUT; k++) begin
            drive(0, 0, 0, 32'h0, 32'h0, 0, 0, 0);
            n_cmp++; if (wr_en !== 1'b0) begin n_fail++;
                $display("FAIL pack_idle_%0d: wr_en=%b want 0", k, wr_en); end
        end
        drive(0, 0, 0, 32'h0, 32'h0, 0, 0, 0);
        n_cmp++; if ({wr_en, wr_addr, count} !== {1'b1, AW'(2), CW'(3)} || wr_data !== {ie, W'(0)}) begin n_fail++;
            $display("FAIL pack_timeout: wr_en=%b addr=%0d count=%0d data=%h want 1/2/3/%h", wr_en, wr_addr, count, wr_data, {ie, W'(0)}); end
    endtask
`endif

    task automatic test_fill_full();
        logic [W-1:0] p;
        logic [W-1:0] q;
        apply_reset();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 1, 1, $urandom | 32'h1, $urandom | 32'h1, 0, 0, 0);
            n_cmp++; if ({wr_en, wr_addr} !== {1'b1, AW'(i)}) begin n_fail++;
                $display("FAIL fill_write_%0d: wr_en=%b addr=%0d want 1/%0d", i, wr_en, wr_addr, i); end
        end
        p = 32'hF00D_0017; q = 32'hBEEF_0017;
        drive(1, 1, 1, p, q, 0, 0, 0);
        n_cmp++; if ({s_stalled, wr_en, full, count} !== {1'b1, 1'b0, 1'b1, CW'(DEPTH)}) begin n_fail++;
            $display("FAIL fill_full_stall: stalled=%b wr_en=%b full=%b count=%0d want 1/0/1/%0d", s_stalled, wr_en, full, count, DEPTH); end
        drive(1, 1, 1, p, q, 0, 1, 0);
        n_cmp++; if ({s_stalled, wr_en, wr_addr, count, full} !== {1'b0, 1'b1, AW'(0), CW'(DEPTH), 1'b1} || wr_data !== {p, q}) begin n_fail++;
            $display("FAIL fill_wrap: stalled=%b wr_en=%b addr=%0d count=%0d data=%h want 0/1/0/%0d/%h", s_stalled, wr_en, wr_addr, count, wr_data, DEPTH, {p, q}); end
    endtask

    task automatic test_flush_clear();
        logic [W-1:0] x;
        int           seen;
        x = 32'h5151_00AA;
        apply_reset();
`ifdef UOP_FILL_PACK_EN
        drive(1, 1, 0, x, 32'h0, 0, 0, 0);
        drive(0, 0, 0, 32'h0, 32'h0, 1, 0, 0);
        n_cmp++; if ({wr_en, wr_addr, count} !== {1'b1, AW'(0), CW'(1)} || wr_data !== {x, W'(0)}) begin n_fail++;
            $display("FAIL flush_held: wr_en=%b addr=%0d count=%0d data=%h want 1/0/1/%h", wr_en, wr_addr, count, wr_data, {x, W'(0)}); end
        drive(1, 1, 0, 32'h6262_00BB, 32'h0, 0, 0, 0);
        drive(0, 0, 0, 32'h0, 32'h0, 0, 0, 1);
        n_cmp++; if ({wr_en, wr_addr, count, empty} !== {1'b0, AW'(0), CW'(0), 1'b1}) begin n_fail++;
            $display("FAIL clear_held: wr_en=%b addr=%0d count=%0d empty=%b want 0/0/0/1", wr_en, wr_addr, count, empty); end
        seen = 0;
        for (int k = 0; k < TIMEOUT + 2; k++) begin
            drive(0, 0, 0, 32'h0, 32'h0, 0, 0, 0);
            if (wr_en !== 1'b0) seen++;
        end
        n_cmp++; if (seen != 0) begin n_fail++;
            $display("FAIL clear_discard: %0d writes after clear, want 0", seen); end
`else
        drive(1, 1, 0, x, 32'h0, 0, 0, 0);
        n_cmp++; if ({wr_en, wr_addr, count} !== {1'b1, AW'(0), CW'(1)} || wr_data !== {x, W'(0)}) begin n_fail++;
            $display("FAIL nopack_single: wr_en=%b addr=%0d count=%0d data=%h want 1/0/1/%h", wr_en, wr_addr, count, wr_data, {x, W'(0)}); end
`endif
        drive(1, 1, 1, 32'h7373_0001, 32'h7373_0002, 0, 0, 1);
        n_cmp++; if ({s_stalled, wr_en, wr_addr, count} !== {1'b1, 1'b0, AW'(0), CW'(0)}) begin n_fail++;
            $display("FAIL clear_beat: stalled=%b wr_en=%b addr=%0d count=%0d want 1/0/0/0", s_stalled, wr_en, wr_addr, count); end
    endtask

    task automatic test_consume_empty();
        apply_reset();
        drive(0, 0, 0, 32'h0, 32'h0, 0, 1, 0);
        n_cmp++; if ({count, empty} !== {CW'(0), 1'b1}) begin n_fail++;
            $display("FAIL consume_empty: count=%0d empty=%b want 0/1", count, empty); end
        for (int i = 0; i < 5; i++) drive(1, 1, 1, $urandom | 32'h1, $urandom | 32'h1, 0, 0, 0);
        n_cmp++; if (count !== CW'(5)) begin n_fail++;
            $display("FAIL consume_fill5: count=%0d want 5", count); end
        drive(1, 1, 1, 32'h9090_0001, 32'h9090_0002, 0, 1, 0);
        n_cmp++; if ({wr_en, count} !== {1'b1, CW'(5)}) begin n_fail++;
            $display("FAIL consume_and_write: wr_en=%b count=%0d want 1/5", wr_en, count); end
        drive(0, 0, 0, 32'h0, 32'h0, 0, 1, 0);
        n_cmp++; if (count !== CW'(4)) begin n_fail++;
            $display("FAIL consume_only: count=%0d want 4", count); end
    endtask

    task automatic test_random();
        bit           pv, v1, v2, fl, rc, cl;
        logic [W-1:0] a, b;
        pv = 0; v1 = 0; v2 = 0; a = '0; b = '0;
        for (int i = 0; i < 800; i++) begin
            // A stalled beat is re-presented unchanged.
            if (!(i > 0 && e_stall)) begin
                pv = ($urandom_range(0, 3) != 0);
                v1 = pv && ($urandom_range(0, 5) != 0);
                v2 = v1 && ($urandom_range(0, 1) != 0);
                a  = $urandom | 32'h1;
                b  = $urandom | 32'h1;
            end
            fl = ($urandom_range(0, 7) == 0);
            rc = ($urandom_range(0, 9) < 3);
            cl = ($urandom_range(0, 63) == 0);
            drive(pv, v1, v2, a, b, fl, rc, cl);
            n_cmp++; if (s_stalled !== e_stall) begin n_fail++;
                $display("FAIL rand_stalled cyc %0d: got %b want %b", i, s_stalled, e_stall); end
            n_cmp++; if (wr_en !== e_wr_en) begin n_fail++;
                $display("FAIL rand_wr_en cyc %0d: got %b want %b", i, wr_en, e_wr_en); end
            if (e_wr_en) begin
                n_cmp++; if (wr_addr !== AW'(e_wr_addr) || wr_data !== e_wr_data) begin n_fail++;
                    $display("FAIL rand_write cyc %0d: addr=%0d data=%h want %0d/%h", i, wr_addr, wr_data, e_wr_addr, e_wr_data); end
            end
            n_cmp++; if ({count, full, empty} !== {CW'(m_count), (m_count == DEPTH), (m_count == 0)}) begin n_fail++;
                $display("FAIL rand_count cyc %0d: count=%0d full=%b empty=%b want %0d", i, count, full, empty, m_count); end
        end
    endtask

    initial begin
        reset = 1'b0; clear = 1'b0; prev_valid = 1'b0; in1_valid = 1'b0; in2_valid = 1'b0;
        in_1 = '0; in_2 = '0; flush = 1'b0; rd_consume = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
`ifdef UOP_FILL_PACK_EN
        test_packing();
`endif
        test_fill_full();
        test_flush_clear();
        test_consume_empty();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uop_fill.md
# uop_fill

Write-side engine for the uop buffer. Takes decoded instructions from the decode stage, up to two per cycle, and packs them into `instruction_bundle` pairs. Each bundle is written into the `UOP_BUF_SIZE`-entry ring at a wrapping write address. The block tracks occupancy against the fetch stage's consume strobe and back-pressures decode when the ring is full.

## Interface
- `UOP_BUF_SIZE`, default 16: ring depth in bundles; power of two, at least 2.
- `FLUSH_TIMEOUT`, default 4: idle cycles before a lone held instruction is written out on its own; at least 1.
- Ports:
  - `clk` — input, 1 — sole clock.
  - `reset` — input, 1 — asynchronous, active-low. All state clears on assertion. Deassertion is synchronised externally.
  - `clear` — input, 1 — synchronous pipeline flush.
  - `prev_valid` — input, 1 — decode is presenting instructions this cycle.
  - `in1_valid`, `in2_valid` — input, 1 each — slot valids. `in2_valid` implies `in1_valid`.
  - `in_1`, `in_2` — input, `fetched_instruction` — incoming instructions.
  - `flush` — input, 1 — force the held instruction out now.
  - `stalled` — output, 1 — decode must hold its inputs.
  - `rd_consume` — input, 1 — fetch stage advanced its read address this cycle.
  - `wr_en` — output, 1 — ring write strobe.
  - `wr_addr` — output, `$clog2(UOP_BUF_SIZE)` — ring write index.
  - `wr_data` — output, `instruction_bundle` — bundle to write.
  - `count` — output, `$clog2(UOP_BUF_SIZE)+1` — bundles resident in the ring, including the one being written this cycle.
  - `full`, `empty` — output, 1 each — `count == UOP_BUF_SIZE` and `count == 0`.

## Operation
- **NOP.** A slot with nothing to put in it is filled with `fetched_instruction` all-zero. All-zero is the NOP encoding.
- **Hold register.** State is `hold_v` plus `hold_q`, holding at most one instruction that is waiting for a partner.
- **Beat count.**
  - A beat is offered when `prev_valid` is high. `n` = number of valid slots (0, 1 or 2).
  - `total = hold_v + n`, range 0..3.
- **space.** `space = (count < UOP_BUF_SIZE) || rd_consume`.
- **Decision per cycle, in priority order:**
  1. **total ≥ 2, space.**
     - Write {oldest, next-oldest}.
     - If `total == 3`, `in_2` goes to the hold register. Otherwise the hold register is emptied.
     - Beat accepted.
  2. **total ≥ 2, !space.**
     - `stalled=1`, nothing written, hold unchanged.
  3. **total == 1, beat present, `flush`=0.**
     - The instruction goes to the hold register. Beat accepted, no write.
  4. **hold_v and (`flush`, or idle counter reached `FLUSH_TIMEOUT`), space.**
     - Write {hold_q, NOP}. hold_v clears.
     - Also taken when `total == 1` with a beat present and `flush=1`: write {in_1, NOP}.
- **Idle counter.**
  - Counts cycles with hold_v=1 and no beat offered.
  - Resets on any beat, and whenever hold_v=0.
  - Saturates at `FLUSH_TIMEOUT`.
- **stalled.** Combinational: `stalled = prev_valid && !accept`.
- **count.** Next value is `count + write_issued - (rd_consume && count != 0)`. `rd_consume` while empty is ignored.
- **clear.** Zeroes `wr_addr`, `count`, hold_v, the idle counter and `wr_en`. No beat is accepted in a `clear` cycle.

## Timing
- **Latency.** `wr_en`, `wr_addr` and `wr_data` are registered. They appear one cycle after the accepting edge and are held for exactly one cycle.
- **Address.** `wr_addr` increments after each write and wraps from `UOP_BUF_SIZE-1` to 0.
- **count.** Updates on the same edge that registers `wr_en`. The slot is reserved at decision time, so full/empty are never stale by a cycle.
- **Simultaneous write and consume at full.** Allowed; `count` is unchanged.
- **Reset values.** All outputs 0 except `empty=1`.
- **Reset or clear mid-beat.** The held instruction is discarded. The beat is not accepted and must be re-presented by decode.

## Configuration
- `UOP_FILL_PACK_EN` defined:
  - Packing and hold behaviour as described above. `FLUSH_TIMEOUT` is active.
- `UOP_FILL_PACK_EN` undefined:
  - No hold register. Each accepted beat writes one bundle: {in_1, in_2 or NOP}.
  - `flush` and `FLUSH_TIMEOUT` are ignored.
  - `stalled = prev_valid && !space`.

## Test plan
- **Reset.** Assert `reset=0` mid-stream → all outputs 0, `empty=1`. First write after release lands at `wr_addr=0`.
- **Packing.** Beats of 1,1,2,1 instructions A; B; C,D; E, no consume → writes {A,B}, then {C,D}. E is held; after 4 idle cycles {E,NOP} is written. `count` ends at 3.
- **Fill to full.** With `rd_consume=0`, 17 two-instruction beats → 16 writes at addresses 0..15, `full=1`, `stalled=1` on beat 17. Then one `rd_consume` → beat 17 is accepted, written at `wr_addr=0` (wrap), `count` stays 16.
- **Flush/clear.**
  - A held instruction plus `flush` → {X,NOP} written the next cycle.
  - `clear` while holding → no write; `wr_addr=0`, `count=0`.
- **Consume while empty.** `rd_consume` with `count=0` → `count` stays 0. Simultaneous write and consume at `count=5` → `count` stays 5.
- **Pack disabled.** Compile without `UOP_FILL_PACK_EN`: a single-instruction beat A → {A,NOP} written the next cycle.
